// File: rtl/mem_access_ctrl.sv
// Arbitrating sequencer between instruction fetch and load/store unit in front of a
// big-endian 64-bit word memory; does sub-word load extension and store read-modify-write.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, IF_RD, D_RD, D_WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  state_t            state_q;
  logic              lastData_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [63:0]       wdata_q;
  logic [31:0]       if_rdata_q;
  logic [63:0]       d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              d_err_q;

  logic              grantData;
  logic              grantFetch;
  logic              dIllegal;
  logic              dRange;
  logic              ifRange;
  logic [63:0]       d_rdata_d;
  logic [63:0]       wdata_d;

  // With both ports pending, the one not served last wins, so neither can starve.
  assign grantData  = d_req && (!if_req || !lastData_q);
  assign grantFetch = if_req && !grantData;
  assign dIllegal   = d_we ? d_funct3[2] : (d_funct3 == 3'b111);
  assign dRange     = d_addr > MAX_ADDR;
  assign ifRange    = if_addr > MAX_ADDR;

  always_comb begin
    d_rdata_d = '0;
    case (funct3_q)
      3'b000:  d_rdata_d = {{56{mem_rdata[63]}}, mem_rdata[63:56]};
      3'b001:  d_rdata_d = {{48{mem_rdata[63]}}, mem_rdata[63:48]};
      3'b010:  d_rdata_d = {{32{mem_rdata[63]}}, mem_rdata[63:32]};
      3'b011:  d_rdata_d = mem_rdata;
      3'b100:  d_rdata_d = {56'b0, mem_rdata[63:56]};
      3'b101:  d_rdata_d = {48'b0, mem_rdata[63:48]};
      3'b110:  d_rdata_d = {32'b0, mem_rdata[63:32]};
      default: d_rdata_d = '0;
    endcase
  end

  // The addressed byte sits in the top lane, so sub-word stores replace the upper bits.
  always_comb begin
    wdata_d = wdata_q;
    case (funct3_q[1:0])
      2'b00:   wdata_d = {wdata_q[7:0],  mem_rdata[55:0]};
      2'b01:   wdata_d = {wdata_q[15:0], mem_rdata[47:0]};
      2'b10:   wdata_d = {wdata_q[31:0], mem_rdata[31:0]};
      default: wdata_d = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lastData_q <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantData) begin
            lastData_q <= 1'b1;
            addr_q     <= d_addr;
            we_q       <= d_we;
            funct3_q   <= d_funct3;
            wdata_q    <= d_wdata;
            if (dIllegal || dRange) begin
              state_q <= DONE;
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
            end else if (d_we && d_funct3 == 3'b011) begin
              state_q <= D_WR;
            end else begin
              state_q <= D_RD;
            end
          end else if (grantFetch) begin
            lastData_q <= 1'b0;
            addr_q     <= if_addr;
            if (ifRange) begin
              state_q    <= DONE;
              if_ack_q   <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              state_q <= IF_RD;
            end
          end
        end
        IF_RD: begin
          if_rdata_q <= mem_rdata[63:32];
          if_ack_q   <= 1'b1;
          state_q    <= DONE;
        end
        D_RD: begin
          if (we_q) begin
            wdata_q <= wdata_d;
            state_q <= D_WR;
          end else begin
            d_rdata_q <= d_rdata_d;
            d_ack_q   <= 1'b1;
            state_q   <= DONE;
          end
        end
        D_WR: begin
          d_ack_q <= 1'b1;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes follow the state directly, so a write in D_WR lands even under reset.
  assign mem_read  = (state_q == IF_RD) || (state_q == D_RD);
  assign mem_write = (state_q == D_WR);
  assign mem_addr  = (mem_read || mem_write) ? addr_q : '0;
  assign mem_wdata = mem_write ? wdata_q : '0;

  assign if_rdata = if_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array memory model, table of transactions with a
// per-port expectation queue, plus arbitration and mid-access reset sequences.
module tb_mem_access_ctrl;

  typedef struct {
    bit          isFetch;
    bit          we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expData;
    bit          expErr;
    int          expLat;
    int          expWr;
    string       name;
  } txn_t;

  typedef struct {
    logic [63:0] expData;
    bit          expErr;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifReq = 1'b0;
  logic [63:0] ifAddr = '0;
  logic [31:0] ifRdata;
  logic        ifAck;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [2:0]  dFunct3 = '0;
  logic [63:0] dAddr = '0;
  logic [63:0] dWdata = '0;
  logic [63:0] dRdata;
  logic        dAck;
  logic        dErr;
  logic        memRead;
  logic        memWrite;
  logic [63:0] memAddr;
  logic [63:0] memWdata;
  logic [63:0] memRdata;

  logic [7:0]  mem [0:2047];
  logic        loadEn = 1'b0;
  int          loadAddr = 0;
  logic [7:0]  loadByte = '0;
  int          wrCount = 0;
  int          nChecks = 0;
  int          nFails = 0;
  exp_t        ifQ[$];
  exp_t        dQ[$];
  bit          ackOrder[$];
  txn_t        vec[21];

  mem_access_ctrl #(.MEM_BYTES(2048), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
    .d_req(dReq), .d_we(dWe), .d_funct3(dFunct3), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata), .d_ack(dAck), .d_err(dErr),
    .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d checks expected completion", nChecks);
    $fatal(1, "[TB] watchdog");
  end

  // Big-endian memory model: the byte at memAddr drives bits [63:56].
  always_comb begin
    memRdata = '0;
    if (memAddr <= 64'd2040)
      for (int i = 0; i < 8; i++) memRdata[63-8*i -: 8] = mem[int'(memAddr) + i];
  end

  always @(posedge clk) begin
    if (loadEn) begin
      mem[loadAddr] <= loadByte;
    end else if (memWrite && memAddr <= 64'd2040) begin
      for (int i = 0; i < 8; i++) mem[int'(memAddr) + i] <= memWdata[63-8*i -: 8];
    end
    if (memWrite) wrCount <= wrCount + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every ack must match the oldest expectation queued for its port.
  always @(negedge clk) begin
    exp_t e;
    if (ifAck || dAck) checkOutput("single ack", {63'b0, ifAck & dAck}, 64'd0);
    if (ifAck) begin
      checkOutput("if_ack expected", {63'b0, ifQ.size() != 0}, 64'd1);
      if (ifQ.size() != 0) begin
        e = ifQ.pop_front();
        checkOutput({e.name, " if_rdata"}, {32'b0, ifRdata}, e.expData);
        ackOrder.push_back(1'b0);
      end
    end
    if (dAck) begin
      checkOutput("d_ack expected", {63'b0, dQ.size() != 0}, 64'd1);
      if (dQ.size() != 0) begin
        e = dQ.pop_front();
        checkOutput({e.name, " d_rdata"}, dRdata, e.expData);
        checkOutput({e.name, " d_err"}, {63'b0, dErr}, {63'b0, e.expErr});
        ackOrder.push_back(1'b1);
      end
    end
  end

  task automatic pokeByte(input int a, input logic [7:0] b);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadByte = b;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " if_rdata"}, {32'b0, ifRdata}, 64'd0);
    checkOutput({tag, " d_rdata"}, dRdata, 64'd0);
    checkOutput({tag, " acks/err"}, {61'b0, ifAck, dAck, dErr}, 64'd0);
    checkOutput({tag, " mem strobes"}, {62'b0, memRead, memWrite}, 64'd0);
    checkOutput({tag, " mem_addr"}, memAddr, 64'd0);
    checkOutput({tag, " mem_wdata"}, memWdata, 64'd0);
  endtask

  function automatic txn_t mk(input string name, input bit isFetch, input bit we,
                              input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] expData,
                              input bit expErr, input int expLat, input int expWr);
    txn_t t;
    t.name = name; t.isFetch = isFetch; t.we = we; t.funct3 = f3; t.addr = addr;
    t.wdata = wdata; t.expData = expData; t.expErr = expErr; t.expLat = expLat;
    t.expWr = expWr;
    return t;
  endfunction

  // Called at a negedge; returns at the negedge after the ack cycle with req dropped.
  task automatic applyStimulus(input txn_t t, input bit checkLat);
    exp_t e;
    int   cycles = 0;
    int   w0 = wrCount;
    bit   seen = 1'b0;
    e.expData = t.expData; e.expErr = t.expErr; e.name = t.name;
    if (t.isFetch) begin
      ifQ.push_back(e);
      ifAddr = t.addr; ifReq = 1'b1;
    end else begin
      dQ.push_back(e);
      dWe = t.we; dFunct3 = t.funct3; dAddr = t.addr; dWdata = t.wdata; dReq = 1'b1;
    end
    while (!seen && cycles < 30) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      seen = t.isFetch ? ifAck : dAck;
    end
    if (t.isFetch) ifReq = 1'b0; else dReq = 1'b0;
    checkOutput({t.name, " ack seen"}, {63'b0, seen}, 64'd1);
    if (checkLat) begin
      checkOutput({t.name, " latency"}, 64'(cycles), 64'(t.expLat));
      checkOutput({t.name, " mem writes"}, 64'(wrCount - w0), 64'(t.expWr));
    end
    @(negedge clk);
  endtask

  initial begin
    int w0;
    vec[0]  = mk("fetch 1023", 1, 0, 3'b000, 64'd1023, 0, 64'h00003083, 0, 2, 0);
    vec[1]  = mk("LB 40",  0, 0, 3'b000, 64'd40, 0, 64'hFFFFFFFFFFFFFF80, 0, 2, 0);
    vec[2]  = mk("LBU 40", 0, 0, 3'b100, 64'd40, 0, 64'h80, 0, 2, 0);
    vec[3]  = mk("LHU 40", 0, 0, 3'b101, 64'd40, 0, 64'h80C0, 0, 2, 0);
    vec[4]  = mk("LW 40",  0, 0, 3'b010, 64'd40, 0, 64'hFFFFFFFF80C0A090, 0, 2, 0);
    vec[5]  = mk("LD 40",  0, 0, 3'b011, 64'd40, 0, 64'h80C0A09088848281, 0, 2, 0);
    vec[6]  = mk("SB 40",  0, 1, 3'b000, 64'd40, 64'h0C, 64'h80C0A09088848281, 0, 3, 1);
    vec[7]  = mk("LD after SB", 0, 0, 3'b011, 64'd40, 0, 64'h0CC0A09088848281, 0, 2, 0);
    vec[8]  = mk("SH 40",  0, 1, 3'b001, 64'd40, 64'h1234, 64'h0CC0A09088848281, 0, 3, 1);
    vec[9]  = mk("LD after SH", 0, 0, 3'b011, 64'd40, 0, 64'h1234A09088848281, 0, 2, 0);
    vec[10] = mk("LH 40",  0, 0, 3'b001, 64'd40, 0, 64'h1234, 0, 2, 0);
    vec[11] = mk("LWU 40", 0, 0, 3'b110, 64'd40, 0, 64'h1234A090, 0, 2, 0);
    vec[12] = mk("SW 2044 range", 0, 1, 3'b010, 64'd2044, 64'h11223344, 64'h1234A090, 1, 1, 0);
    vec[13] = mk("load f3=111", 0, 0, 3'b111, 64'd40, 0, 64'h1234A090, 1, 1, 0);
    vec[14] = mk("SD 48",  0, 1, 3'b011, 64'd48, 64'h1122334455667788, 64'h1234A090, 0, 2, 1);
    vec[15] = mk("LD 48",  0, 0, 3'b011, 64'd48, 0, 64'h1122334455667788, 0, 2, 0);
    vec[16] = mk("fetch 2044 range", 1, 0, 3'b000, 64'd2044, 0, 64'h0, 0, 1, 0);
    vec[17] = mk("store f3=100", 0, 1, 3'b100, 64'd40, 64'hFF, 64'h1122334455667788, 1, 1, 0);
    vec[18] = mk("SW 40",  0, 1, 3'b010, 64'd40, 64'hDEADBEEF, 64'h1122334455667788, 0, 3, 1);
    vec[19] = mk("LD after SW", 0, 0, 3'b011, 64'd40, 0, 64'hDEADBEEF88848281, 0, 2, 0);
    vec[20] = mk("fetch 40", 1, 0, 3'b000, 64'd40, 0, 64'hDEADBEEF, 0, 2, 0);

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    pokeByte(1025, 8'h30); pokeByte(1026, 8'h83);
    pokeByte(40, 8'h80); pokeByte(41, 8'hC0); pokeByte(42, 8'hA0); pokeByte(43, 8'h90);
    pokeByte(44, 8'h88); pokeByte(45, 8'h84); pokeByte(46, 8'h82); pokeByte(47, 8'h81);
    for (int i = 2040; i < 2048; i++) pokeByte(i, 8'hA5);

    @(negedge clk);
    checkQuiet("reset");
    reset = 1'b0;

    // Both ports request from reset: fetch must win first since last grant resets to data.
    fork
      begin
        applyStimulus(mk("alt fetch1", 1, 0, 3'b000, 64'd1023, 0, 64'h00003083, 0, 0, 0), 0);
        @(negedge clk);
        applyStimulus(mk("alt fetch2", 1, 0, 3'b000, 64'd1023, 0, 64'h00003083, 0, 0, 0), 0);
      end
      begin
        applyStimulus(mk("alt load1", 0, 0, 3'b011, 64'd40, 0, 64'h80C0A09088848281, 0, 0, 0), 0);
        @(negedge clk);
        applyStimulus(mk("alt load2", 0, 0, 3'b011, 64'd40, 0, 64'h80C0A09088848281, 0, 0, 0), 0);
      end
    join
    checkOutput("grant count", 64'(ackOrder.size()), 64'd4);
    if (ackOrder.size() == 4)
      checkOutput("grant order", {60'b0, ackOrder[0], ackOrder[1], ackOrder[2], ackOrder[3]},
                  64'b0101);
    checkOutput("alt mem writes", 64'(wrCount), 64'd0);

    for (int i = 0; i < 21; i++) applyStimulus(vec[i], 1);
    checkOutput("byte 2044 untouched", {56'b0, mem[2044]}, 64'hA5);

    // Reset while an SB sits in D_RD: access abandoned, no write, no ack.
    w0 = wrCount;
    dWe = 1'b1; dFunct3 = 3'b000; dAddr = 64'd40; dWdata = 64'hFF; dReq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("SB in D_RD reads", {62'b0, memRead, memWrite}, 64'b10);
    reset = 1'b1; dReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkQuiet("mid-SB reset");
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid-SB reset writes", 64'(wrCount - w0), 64'd0);
    checkOutput("byte 40 after abort", {56'b0, mem[40]}, 64'hDE);
    applyStimulus(mk("fetch after reset", 1, 0, 3'b000, 64'd40, 0, 64'hDEADBEEF, 0, 2, 0), 1);

    repeat (3) @(negedge clk);
    checkOutput("if queue drained", 64'(ifQ.size()), 64'd0);
    checkOutput("d queue drained", 64'(dQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
